// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port SRAM between instruction fetch and load/store,
// sequencing each access through a multi-cycle read or write strobe FSM.
module mem_port_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int SRAM_ADDR_W   = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [15:0]            if_addr,
    output logic [15:0]            if_data,
    output logic                   if_valid,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [15:0]            mem_addr,
    input  logic [15:0]            mem_wdata,
    output logic [15:0]            mem_rdata,
    output logic                   mem_done,
    output logic                   stall_if,
    output logic                   stall_mem,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_o,
    input  logic [15:0]            sram_dq_i,
    output logic                   sram_dq_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);

    typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic                   owner_q, owner_d;
    logic                   last_mem_q, last_mem_d;
    logic                   is_write_q, is_write_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]            sram_dq_q, sram_dq_d;
    logic [15:0]            if_data_q, if_data_d;
    logic [15:0]            mem_rdata_q, mem_rdata_d;
    logic                   if_valid_q, if_valid_d;
    logic                   mem_done_q, mem_done_d;

    logic mem_pending;
    logic grant_mem;

    assign mem_pending = mem_read | mem_write;
    // When both stages are waiting, the stage that did not own the last access wins.
    assign grant_mem   = mem_pending & (~if_req | ~last_mem_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        owner_d     = owner_q;
        last_mem_d  = last_mem_q;
        is_write_d  = is_write_q;
        sram_addr_d = sram_addr_q;
        sram_dq_d   = sram_dq_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_valid_d  = 1'b0;
        mem_done_d  = 1'b0;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_pending || if_req) begin
                    owner_d     = grant_mem;
                    is_write_d  = grant_mem & mem_write;
                    sram_addr_d = grant_mem ? SRAM_ADDR_W'(mem_addr) : SRAM_ADDR_W'(if_addr);
                    sram_dq_d   = mem_wdata;
                    wait_cnt_d  = 4'd0;
                    state_d     = (grant_mem && mem_write) ? WR_SETUP : READ;
                end
            end
            READ: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                if (wait_cnt_q == LAST_CNT) begin
                    if (owner_q) begin
                        mem_rdata_d = sram_dq_i;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_data_d  = sram_dq_i;
                        if_valid_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            WR_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                wait_cnt_d = 4'd0;
                state_d    = WR_PULSE;
            end
            WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_dq_oe = 1'b1;
                if (wait_cnt_q == LAST_CNT) begin
                    mem_done_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            DONE: begin
                // Data hold cycle after a write keeps the bus driven past the we_n rise.
                sram_dq_oe = is_write_q;
                last_mem_d = owner_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            owner_q     <= 1'b0;
            last_mem_q  <= 1'b0;
            is_write_q  <= 1'b0;
            sram_addr_q <= '0;
            sram_dq_q   <= 16'h0000;
            if_data_q   <= 16'h0000;
            mem_rdata_q <= 16'h0000;
            if_valid_q  <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            owner_q     <= owner_d;
            last_mem_q  <= last_mem_d;
            is_write_q  <= is_write_d;
            sram_addr_q <= sram_addr_d;
            sram_dq_q   <= sram_dq_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign sram_addr = sram_addr_q;
    assign sram_dq_o = sram_dq_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign if_valid  = if_valid_q;
    assign mem_done  = mem_done_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = mem_pending & ~mem_done_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port instruction/data SRAM between the IF stage (instruction fetch) and the MEM stage (LW, LW_SP, SW, SW_SP) of the pipelined CPU. It sequences each SRAM access through a multi-cycle read or write FSM and drives the control strobes. It raises per-stage stall signals so the pipeline freezes while a stage's access is pending. The MEM-stage request inputs are the registered `memRead`/`memWrite` control bits produced by the instruction decoder.

## Interface
- `ACCESS_CYCLES`, default 2: SRAM strobe width in cycles, legal range 1..15.
- `SRAM_ADDR_W`, default 18: SRAM address width; CPU addresses are zero-extended.

- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `if_req`  in  1  IF stage requests a fetch; held until `if_valid`.
- `if_addr`  in  16  fetch address (PC).
- `if_data`  out  16  fetched instruction; valid when `if_valid`=1, otherwise holds its last value.
- `if_valid`  out  1  one-cycle pulse marking fetch completion.
- `mem_read`  in  1  MEM stage load request; held until `mem_done`.
- `mem_write`  in  1  MEM stage store request; held until `mem_done`.
- `mem_addr`  in  16  load/store address.
- `mem_wdata`  in  16  store data.
- `mem_rdata`  out  16  load data; valid when `mem_done`=1 for a read.
- `mem_done`  out  1  one-cycle pulse marking load/store completion.
- `stall_if`  out  1  combinational: `if_req & ~if_valid`.
- `stall_mem`  out  1  combinational: `(mem_read | mem_write) & ~mem_done`.
- `sram_addr`  out  SRAM_ADDR_W  registered SRAM address.
- `sram_dq_o`  out  16  write data to the SRAM data bus.
- `sram_dq_i`  in  16  read data from the SRAM data bus.
- `sram_dq_oe`  out  1  tri-state enable for `sram_dq_o`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low SRAM strobes.

## Operation
- FSM states: IDLE, READ, WR_SETUP, WR_PULSE, DONE. A 4-bit `wait_cnt` counts strobe cycles. An `owner` bit records the granted requester (0=IF, 1=MEM). A `last_mem` bit records the owner of the previous completed access.
- **Arbitration in IDLE**
  - Only MEM pending: grant MEM.
  - Only IF pending: grant IF.
  - Both pending: grant IF if `last_mem`=1, else grant MEM. This alternation prevents IF starvation on back-to-back loads.
  - `mem_read` and `mem_write` both high: treat as a write.
- **Grant**
  - Latch `sram_addr` = {zeros, addr} and `sram_dq_o` = `mem_wdata`.
  - Go to READ (IF fetch or MEM read) or to WR_SETUP (MEM write).
- **READ**
  - `ce_n`=0, `oe_n`=0, `we_n`=1, `dq_oe`=0.
  - Stay for ACCESS_CYCLES cycles.
  - On the last cycle, capture `sram_dq_i` into `if_data` or `mem_rdata` according to `owner`, then go to DONE.
- **WR_SETUP**
  - `ce_n`=0, `oe_n`=1, `we_n`=1, `dq_oe`=1.
  - Lasts 1 cycle, then go to WR_PULSE.
- **WR_PULSE**
  - `ce_n`=0, `we_n`=0, `dq_oe`=1.
  - Lasts ACCESS_CYCLES cycles, then go to DONE. Address and data stay stable throughout.
- **DONE**
  - All strobes deasserted; `dq_oe` stays 1 for one hold cycle after a write and is 0 after a read.
  - Pulse `if_valid` or `mem_done` for the owner.
  - Update `last_mem` = `owner` and return to IDLE.
  - No new request is accepted in DONE.
- **Request withdrawn mid-access:** the access still completes and the done pulse is still issued; upstream ignores it.
- **Reset** (any state, including mid-write): next state is IDLE.
  - `ce_n`/`oe_n`/`we_n`=1, `dq_oe`=0, `sram_addr`=0, `sram_dq_o`=0.
  - `if_data`=0, `mem_rdata`=0, `if_valid`=0, `mem_done`=0, `wait_cnt`=0, `last_mem`=0.

## Timing
- A request seen at a rising edge in IDLE is granted at that edge.
- Read: grant edge to `if_valid`/`mem_done` high = ACCESS_CYCLES+1 cycles; data valid in the same cycle as the pulse.
- Write: grant to `mem_done` = ACCESS_CYCLES+2 cycles.
- Minimum spacing between consecutive grants is latency+1 cycles, because the FSM passes through IDLE after DONE.
- Stall outputs are combinational from inputs and registered pulses. They drop in the done cycle, so the pipeline advances on that edge.
- `we_n` never falls in the same cycle that address or data change.

## Test plan
- **Single fetch.** ACCESS_CYCLES=2, `if_req`=1, `if_addr`=0x0010, SRAM[0x10]=0x0800. Required: `if_valid` high exactly 3 cycles after grant, `if_data`=0x0800, `stall_if` low in that cycle.
- **Load/fetch conflict.** `mem_read`@0x8000 and `if_req` asserted in the same cycle. Required: MEM granted first, `mem_done` after 3 cycles, IF granted next, `if_valid` 4 cycles after `mem_done`.
- **Store.** `mem_write`@0x1234, data 0xBEEF. Required: exactly one WR_SETUP cycle with `we_n`=1, then `we_n`=0 for 2 cycles, `mem_done` 4 cycles after grant. Read-back of 0x1234 returns 0xBEEF.
- **Back-to-back loads with `if_req` held.** Required: grants alternate MEM, IF, MEM; IF is never skipped twice in a row.
- **Reset during WR_PULSE.** Required: next cycle `we_n`=1, `ce_n`=1, `dq_oe`=0, no `mem_done` pulse, FSM in IDLE.
- **`mem_read` and `mem_write` both high.** Required: a write sequence is issued and `mem_rdata` is unchanged.
